// File: rtl/sram_pkg.sv
// sram_pkg: shared types and helpers for the 1W/NR zero-fill SRAM.
//   sram_state_e : clear-sequencer states
//   addr_w()     : address width for a given depth (min 1 bit)
package sram_pkg;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } sram_state_e;

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/sram_clear_fsm.sv
// sram_clear_fsm: zero-fill sequencer for sram_1wnr_bwe_clr.
// Walks every word once after reset or a CLR request, asserting BUSY
// for exactly DEPTH cycles.
// Ports:
//   CLK, RESET     clock, async active-high reset
//   CLR            fill request, only honoured in S_READY
//   BUSY           high while the fill runs
//   clr_we         zero-write strobe into the array
//   clr_addr       word being zeroed this cycle
module sram_clear_fsm
  import sram_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int AW    = addr_w(DEPTH)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          CLR,
  output logic          BUSY,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = (AW)'(DEPTH - 1);

  sram_state_e   state, state_n;
  logic [AW-1:0] cnt, cnt_n;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_n = cnt + 1'b1;
        // Last word is written on this edge; leave with counter parked at 0.
        if (cnt == LAST) begin
          state_n = S_READY;
          cnt_n   = '0;
        end
      end
      S_READY: begin
        if (CLR) begin
          state_n = S_CLEAR;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_CLEAR;
        cnt_n   = '0;
      end
    endcase
  end

  assign BUSY     = (state == S_CLEAR);
  assign clr_we   = BUSY;
  assign clr_addr = cnt;

endmodule

// File: rtl/sram_1wnr_bwe_clr.sv
// sram_1wnr_bwe_clr: 1-write / READ_PORTS-read synchronous SRAM with
// active-low bit write enables and a hardware zero-fill sequencer.
// Ports:
//   CLK, RESET   clock, async active-high reset (clears Q, restarts fill)
//   CLR          request zero-fill of the whole array (READY only)
//   BUSY         fill in progress; reads/writes ignored, Q holds
//   WEC, BWC     write enable / per-bit write enable, active low
//   DC, AC       write data / address (AC >= DEPTH drops the write)
//   RE, A        per-port active-low read enable / packed addresses
//   Q            per-port registered read data, 1-cycle latency
// Config macro: SRAM_WR_BYPASS_EN -- same-cycle same-address read returns
//   the merged word being written; otherwise read-before-write.
module sram_1wnr_bwe_clr
  import sram_pkg::*;
#(
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 32,
  parameter  int READ_PORTS = 2,
  localparam int AW         = addr_w(DEPTH)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        CLR,
  output logic                        BUSY,
  input  logic                        WEC,
  input  logic [WIDTH-1:0]            BWC,
  input  logic [WIDTH-1:0]            DC,
  input  logic [AW-1:0]               AC,
  input  logic [READ_PORTS-1:0]       RE,
  input  logic [READ_PORTS*AW-1:0]    A,
  output logic [READ_PORTS*WIDTH-1:0] Q
);

  // One extra bit so DEPTH == 2**AW still compares correctly.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic             busy, clr_we;
  logic [AW-1:0]    clr_addr;
  logic [WIDTH-1:0] mem [DEPTH];

  sram_clear_fsm #(.DEPTH(DEPTH)) u_clr (
    .CLK      (CLK),
    .RESET    (RESET),
    .CLR      (CLR),
    .BUSY     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign BUSY = busy;

  logic             ac_ok, wr_act;
  logic [WIDTH-1:0] old_w, wr_word;

  assign ac_ok   = {1'b0, AC} < DEPTH_W;
  assign wr_act  = !busy && !WEC && ac_ok;
  assign old_w   = ac_ok ? mem[AC] : '0;
  assign wr_word = (DC & ~BWC) | (old_w & BWC);

  // clr_we and wr_act are mutually exclusive (wr_act requires !busy).
  always_ff @(posedge CLK) begin
    if (clr_we)      mem[clr_addr] <= '0;
    else if (wr_act) mem[AC]       <= wr_word;
  end

  for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
    logic [AW-1:0]    ra;
    logic             ra_ok;
    logic [WIDTH-1:0] rd_word, q_r;

    assign ra    = A[i*AW +: AW];
    assign ra_ok = {1'b0, ra} < DEPTH_W;

`ifdef SRAM_WR_BYPASS_EN
    // wr_act implies AC in range, so a matching ra is in range too.
    assign rd_word = !ra_ok                  ? '0      :
                     (wr_act && (ra == AC))  ? wr_word : mem[ra];
`else
    assign rd_word = ra_ok ? mem[ra] : '0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)                q_r <= '0;
      else if (!busy && !RE[i]) q_r <= rd_word;
    end

    assign Q[i*WIDTH +: WIDTH] = q_r;
  end

endmodule

// File: tb/tb_sram_1wnr_bwe_clr.sv
module tb_sram_1wnr_bwe_clr;

  localparam int W = 32, D = 20, RP = 3, AW = 5;

  logic          CLK = 1'b0, RESET = 1'b1, CLR = 1'b0, BUSY, WEC = 1'b1;
  logic [W-1:0]  BWC = '1, DC = '0;
  logic [AW-1:0] AC = '0;
  logic [RP-1:0] RE = '1;
  logic [RP*AW-1:0] A = '0;
  logic [RP*W-1:0]  Q;

  sram_1wnr_bwe_clr #(.WIDTH(W), .DEPTH(D), .READ_PORTS(RP)) dut (
    .CLK(CLK), .RESET(RESET), .CLR(CLR), .BUSY(BUSY), .WEC(WEC), .BWC(BWC),
    .DC(DC), .AC(AC), .RE(RE), .A(A), .Q(Q)
  );

  always #5 CLK = ~CLK;

  typedef struct { int due; int port; logic [W-1:0] val; } exp_t;
  exp_t sbq[$];
  int   cyc = 0, nvec = 0, nerr = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(string nm, logic [W-1:0] got, logic [W-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endfunction

  // Monitor: pops every expectation due on the edge just taken.
  always @(negedge CLK) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk($sformatf("q%0d@cyc%0d", e.port, e.due), Q[e.port*W +: W], e.val);
    end
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle();
    WEC = 1'b1; BWC = '1; RE = '1; CLR = 1'b0;
  endtask

  task automatic expect_q(input int p, input logic [W-1:0] v);
    exp_t e;
    e.due = cyc + 1; e.port = p; e.val = v;
    sbq.push_back(e);
  endtask

  task automatic rd(input int p, input logic [AW-1:0] a, input logic [W-1:0] v);
    RE[p] = 1'b0;
    A[p*AW +: AW] = a;
    expect_q(p, v);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] bw);
    WEC = 1'b0; AC = a; DC = d; BWC = bw;
  endtask

  task automatic count_busy(input string nm);
    int n;
    n = 0;
    while (BUSY === 1'b1 && n < 100) begin tick(); n++; end
    chk(nm, n, 20);
  endtask

  logic [W-1:0] v;

  initial begin
    idle();
    tick(); tick();
    // reset state
    chk("rst_busy", {31'd0, BUSY}, 1);
    for (int p = 0; p < RP; p++) chk($sformatf("rst_q%0d", p), Q[p*W +: W], 0);
    RESET = 1'b0;
    count_busy("busy_after_reset");

    // 1: whole array zero, all ports
    for (int a = 0; a < D; a++) begin
      idle();
      for (int p = 0; p < RP; p++) rd(p, a[AW-1:0], 32'h0);
      tick();
    end

    // 2: full write then masked write, then BWC all-ones no-op
    idle(); wr(5, 32'hDEADBEEF, 32'h0); tick();
    idle(); wr(5, 32'h12345678, 32'hFFFF0000); tick();
    idle(); wr(5, 32'hFFFFFFFF, 32'hFFFFFFFF); tick();
    idle(); for (int p = 0; p < RP; p++) rd(p, 5, 32'hDEAD5678); tick();

    // 3: same-cycle write/read at 7
    idle(); wr(7, 32'h11111111, 32'h0); tick();
`ifdef SRAM_WR_BYPASS_EN
    v = 32'hA5A5A5A5;
`else
    v = 32'h11111111;
`endif
    idle(); wr(7, 32'hA5A5A5A5, 32'h0); rd(0, 7, v); tick();
    idle(); rd(0, 7, 32'hA5A5A5A5); tick();
    // RE high: Q holds even with address moved
    idle(); A = '0; expect_q(0, 32'hA5A5A5A5); tick();

    // 4: out-of-range write/reads, edge words 0 and 19
    idle(); wr(25, 32'hCAFEF00D, 32'h0); tick();
    idle(); wr(19, 32'h19191919, 32'h0); tick();
    idle(); wr(0, 32'h00C0FFEE, 32'h0); tick();
    idle(); rd(0, 31, 0); rd(1, 25, 0); rd(2, 20, 0); tick();
    for (int a = 0; a < D; a++) begin
      idle();
      v = (a == 5) ? 32'hDEAD5678 : (a == 7) ? 32'hA5A5A5A5 :
          (a == 19) ? 32'h19191919 : (a == 0) ? 32'h00C0FFEE : 32'h0;
      rd(a % RP, a[AW-1:0], v);
      tick();
    end

    // 5: fill with index, CLR with same-cycle read, busy window ignores access
    for (int a = 0; a < D; a++) begin idle(); wr(a[AW-1:0], a, 32'h0); tick(); end
    idle(); rd(0, 11, 11); rd(1, 19, 19); tick();
    idle(); CLR = 1'b1; wr(3, 32'hFFFF, 32'h0);
    rd(0, 4, 4); rd(1, 9, 9); rd(2, 13, 13); tick();
    begin
      int n;
      n = 0;
      while (BUSY === 1'b1 && n < 100) begin
        idle(); CLR = 1'b1; wr(0, 32'hFFFFFFFF, 32'h0);
        rd(0, 1, 4); rd(1, 1, 9); rd(2, 1, 13);
        tick(); n++;
      end
      chk("busy_after_clr", n, 20);
    end
    for (int a = 0; a < D; a++) begin idle(); rd(a % RP, a[AW-1:0], 0); tick(); end

    // 6: reset in the middle of a fill
    idle(); wr(2, 32'h55, 32'h0); tick();
    idle(); for (int p = 0; p < RP; p++) rd(p, 2, 32'h55); tick();
    idle(); CLR = 1'b1; tick();
    idle(); repeat (10) tick();
    RESET = 1'b1; #1;
    chk("midfill_busy", {31'd0, BUSY}, 1);
    for (int p = 0; p < RP; p++) chk($sformatf("midfill_q%0d", p), Q[p*W +: W], 0);
    tick(); RESET = 1'b0;
    count_busy("busy_after_midfill_reset");
    idle(); for (int p = 0; p < RP; p++) rd(p, 2, 0); tick();

    idle(); tick(); tick(); tick();
    if (sbq.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL drain: %0d expectations left, required 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
